// File: rtl/if_id_skid_if.sv
// Fetch-to-decode handshake bundle for the IF/ID skid buffer.
// The slave modport is the buffer's view; master is the view of whoever drives fetch and decode.
interface if_id_skid_if #(
  parameter int INSTR_W = 24,
  parameter int PC_W    = 24
);
  logic               in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc;
  logic               in_ready;
  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic               out_ready;
  logic               flush;
  logic [1:0]         count;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready, flush,
    output in_ready, out_valid, out_instr, out_pc, count
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready, flush,
    input  in_ready, out_valid, out_instr, out_pc, count
  );
endinterface

// File: rtl/if_id_skid.sv
// Two-entry IF/ID skid buffer: main drives decode, skid absorbs one extra fetch
// while decode stalls, so in_ready depends only on registered state.
module if_id_skid #(
  parameter int INSTR_W = 24,
  parameter int PC_W    = 24
) (
  input logic          clk,
  input logic          reset,
  if_id_skid_if.slave  bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_main_valid;
  logic               r_skid_valid;
  logic [INSTR_W-1:0] r_main_instr;
  logic [PC_W-1:0]    r_main_pc;
  logic [INSTR_W-1:0] r_skid_instr;
  logic [PC_W-1:0]    r_skid_pc;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid_in;

  assign bus.in_ready  = ~r_skid_valid;
  assign bus.out_valid = r_main_valid;
  assign bus.out_instr = r_main_instr;
  assign bus.out_pc    = r_main_pc;
  assign bus.count     = r_state;

  assign w_in_xfer  = bus.in_valid & bus.in_ready;
  assign w_out_xfer = r_main_valid & bus.out_ready;

  always_comb begin
    w_state_next     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid_in   = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_in_xfer) begin
          w_load_main_in = 1'b1;
          w_state_next   = S_ONE;
        end
      end
      S_ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_load_main_in = 1'b1;
        end else if (w_in_xfer) begin
          w_load_skid_in = 1'b1;
          w_state_next   = S_FULL;
        end else if (w_out_xfer) begin
          w_state_next = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_out_xfer) begin
          w_load_main_skid = 1'b1;
          w_state_next     = S_ONE;
        end
      end
      default: w_state_next = S_EMPTY;
    endcase
    // A redirect wins over everything; any output transfer this cycle is still consumed.
    if (bus.flush) begin
      w_state_next     = S_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid_in   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_EMPTY;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_main_valid <= (w_state_next != S_EMPTY);
      r_skid_valid <= (w_state_next == S_FULL);
    end
  end

  // Payload carries no reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (w_load_main_in) begin
      r_main_instr <= bus.in_instr;
      r_main_pc    <= bus.in_pc;
    end else if (w_load_main_skid) begin
      r_main_instr <= r_skid_instr;
      r_main_pc    <= r_skid_pc;
    end
    if (w_load_skid_in) begin
      r_skid_instr <= bus.in_instr;
      r_skid_pc    <= bus.in_pc;
    end
  end

endmodule

// File: tb/tb_if_id_skid.sv
// Directed and randomized check of the IF/ID skid buffer against hand-computed
// values and a small FIFO model.
module tb_if_id_skid;
  localparam int INSTR_W = 24;
  localparam int PC_W    = 24;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   verbose = 1'b1;

  if_id_skid_if #(.INSTR_W(INSTR_W), .PC_W(PC_W)) bus ();

  if_id_skid #(.INSTR_W(INSTR_W), .PC_W(PC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (verbose && bus.out_valid && bus.out_ready)
      $display("decode takes instr=%0d pc=%0d", bus.out_instr, bus.out_pc);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int instr, input int pc);
    bus.in_valid = v;
    bus.in_instr = INSTR_W'(instr);
    bus.in_pc    = PC_W'(pc);
  endtask

  task automatic expect_out(input string tag, input logic v, input int instr, input int pc, input int cnt);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, "_count"}, 32'(bus.count), 32'(cnt));
    if (v) begin
      chk({tag, "_instr"}, 32'(bus.out_instr), 32'(instr));
      chk({tag, "_pc"}, 32'(bus.out_pc), 32'(pc));
    end
  endtask

  logic [INSTR_W+PC_W-1:0] q[$];

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;

    // Reset held from time zero, no clock edge yet
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_count", 32'(bus.count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Streaming at full rate
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i + 1, i);
      tick();
      expect_out("stream", 1'b1, i + 1, i, 1);
    end
    drive(1'b0, 0, 0);
    tick();
    expect_out("stream_drain", 1'b0, 0, 0, 0);

    // Backpressure
    bus.out_ready = 1'b0;
    drive(1'b1, 1, 0);
    tick();
    expect_out("bp_one", 1'b1, 1, 0, 1);
    chk("bp_one_in_ready", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 2, 1);
    tick();
    expect_out("bp_full", 1'b1, 1, 0, 2);
    chk("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 3, 2);
    tick();
    expect_out("bp_stall", 1'b1, 1, 0, 2);
    drive(1'b0, 0, 0);
    bus.out_ready = 1'b1;
    tick();
    expect_out("bp_pop1", 1'b1, 2, 1, 1);
    tick();
    expect_out("bp_pop2", 1'b0, 0, 0, 0);

    // Flush from FULL with a simultaneous push
    bus.out_ready = 1'b0;
    drive(1'b1, 5, 4);
    tick();
    drive(1'b1, 6, 5);
    tick();
    expect_out("fl_full", 1'b1, 5, 4, 2);
    bus.flush = 1'b1;
    drive(1'b1, 7, 6);
    tick();
    expect_out("fl_flush", 1'b0, 0, 0, 0);
    chk("fl_in_ready", 32'(bus.in_ready), 32'd1);
    bus.flush = 1'b0;
    drive(1'b0, 0, 0);
    tick();
    expect_out("fl_idle", 1'b0, 0, 0, 0);
    drive(1'b1, 8, 1);
    tick();
    expect_out("fl_push", 1'b1, 8, 1, 1);
    bus.out_ready = 1'b1;
    drive(1'b0, 0, 0);
    tick();
    expect_out("fl_drain", 1'b0, 0, 0, 0);

    // Asynchronous reset between edges while FULL
    bus.out_ready = 1'b0;
    drive(1'b1, 10, 10);
    tick();
    drive(1'b1, 11, 11);
    tick();
    expect_out("ar_full", 1'b1, 10, 10, 2);
    drive(1'b0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_out_valid", 32'(bus.out_valid), 32'd0);
    chk("ar_in_ready", 32'(bus.in_ready), 32'd1);
    chk("ar_count", 32'(bus.count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b1, 9, 9);
    bus.out_ready = 1'b1;
    tick();
    expect_out("ar_first", 1'b1, 9, 9, 1);
    drive(1'b0, 0, 0);
    tick();
    expect_out("ar_drain", 1'b0, 0, 0, 0);

    // Random traffic against a FIFO model
    verbose = 1'b0;
    begin
      int seq = 100;
      for (int cyc = 0; cyc < 10000; cyc++) begin
        logic fl, iv, ordy, out_x, in_x;
        int   pc;
        fl   = ($urandom_range(0, 99) < 2);
        iv   = 1'($urandom_range(0, 1));
        ordy = 1'($urandom_range(0, 1));
        pc   = int'($urandom_range(0, 16777215));
        bus.flush     = fl;
        bus.out_ready = ordy;
        drive(iv, seq, pc);
        out_x = (q.size() > 0) && ordy;
        in_x  = (q.size() < 2) && iv;
        tick();
        if (out_x) void'(q.pop_front());
        if (fl) begin
          q.delete();
        end else if (in_x) begin
          q.push_back({INSTR_W'(seq), PC_W'(pc)});
          seq++;
        end
        chk("rnd_count", 32'(bus.count), 32'(q.size()));
        chk("rnd_out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        chk("rnd_in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
          chk("rnd_instr", 32'(bus.out_instr), 32'(q[0][INSTR_W+PC_W-1:PC_W]));
          chk("rnd_pc", 32'(bus.out_pc), 32'(q[0][PC_W-1:0]));
        end
      end
    end
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
